// File: rtl/wb4_sync_fifo_pack.sv
// -----------------------------------------------------------------------------
// wb4_sync_fifo_pack
//
// Single-clock Wishbone B4 (pipelined) packing FIFO. P_RATIO narrow units
// written on the input port are assembled into one wide word. The word is
// stored in a P_DEPTH-entry FIFO and read out on the output port.
//
// Optional feature macro: WB4_FIFO_FLUSH_EN
//   defined   : i_wb4_in_sflush pushes a partially assembled word. Unfilled
//               lanes are zero. A per-entry lane mask is stored with the word.
//   undefined : flush is ignored and no mask storage is built. Partial words
//               stay buffered. o_wb4_out_smask reads all-ones on every ack.
//
// Ports
//   i_wb4_sclk        clock, rising edge
//   i_wb4_srst_n      async active-low reset
//   i_wb4_in_scyc     write cycle
//   i_wb4_in_sstb     write strobe
//   i_wb4_in_sdata    write unit
//   i_wb4_in_sflush   push the partial word
//   o_wb4_in_sack     write ack, one cycle after each accepted unit
//   o_wb4_in_sstall   word storage full
//   i_wb4_out_scyc    read cycle
//   i_wb4_out_sstb    read strobe
//   o_wb4_out_sack    read ack; data and mask are valid while high
//   o_wb4_out_sdata   read word
//   o_wb4_out_smask   valid lanes of the read word
//   o_wb4_out_sstall  word storage empty
//   o_level           stored words, 0..P_DEPTH
// -----------------------------------------------------------------------------
module wb4_sync_fifo_pack #(
  parameter int P_UNIT_MSB  = 7,
  parameter int P_RATIO     = 4,
  parameter int P_DEPTH     = 16,
  parameter bit P_LSB_FIRST = 1'b1
) (
  input  logic                                i_wb4_sclk,
  input  logic                                i_wb4_srst_n,
  input  logic                                i_wb4_in_scyc,
  input  logic                                i_wb4_in_sstb,
  input  logic [P_UNIT_MSB:0]                 i_wb4_in_sdata,
  input  logic                                i_wb4_in_sflush,
  output logic                                o_wb4_in_sack,
  output logic                                o_wb4_in_sstall,
  input  logic                                i_wb4_out_scyc,
  input  logic                                i_wb4_out_sstb,
  output logic                                o_wb4_out_sack,
  output logic [(P_UNIT_MSB+1)*P_RATIO-1:0]   o_wb4_out_sdata,
  output logic [P_RATIO-1:0]                  o_wb4_out_smask,
  output logic                                o_wb4_out_sstall,
  output logic [$clog2(P_DEPTH):0]            o_level
);

  localparam int UW = P_UNIT_MSB + 1;
  localparam int W  = UW * P_RATIO;
  localparam int L  = $clog2(P_DEPTH) + 1;
  localparam int AW = L - 1;
  localparam int CW = $clog2(P_RATIO);

  logic [L-1:0]       wr_ptr, rd_ptr;
  logic [L-1:0]       wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic               full_nxt, empty_nxt;
  logic [CW-1:0]      r_unit_cnt;
  logic [W-1:0]       r_asm, asm_nxt;
  logic               we, re, complete, flush_ok, push;
  logic [P_RATIO-1:0] head_mask;
  int                 lane_idx;
  int                 fill_cnt;

  logic [W-1:0]       mem_data [P_DEPTH];

  // Write/read qualification and word assembly. The incoming unit is merged
  // into asm_nxt so a completing or flushing write pushes it on the same edge.
  always_comb begin
    we       = i_wb4_in_scyc & i_wb4_in_sstb & ~o_wb4_in_sstall;
    re       = i_wb4_out_scyc & i_wb4_out_sstb & ~o_wb4_out_sstall;
    complete = we && (int'(r_unit_cnt) == P_RATIO - 1);
    fill_cnt = int'(r_unit_cnt) + (we ? 1 : 0);
    lane_idx = P_LSB_FIRST ? int'(r_unit_cnt) : (P_RATIO - 1 - int'(r_unit_cnt));
    asm_nxt  = r_asm;
    if (we) begin
      for (int i = 0; i < P_RATIO; i++) begin
        if (i == lane_idx) asm_nxt[i*UW +: UW] = i_wb4_in_sdata;
      end
    end
    // A completing write takes priority; the flush then adds no second push.
    push = complete | (flush_ok & (fill_cnt > 0));
  end

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{(L-1){1'b0}}, push};
    rd_ptr_nxt = rd_ptr + {{(L-1){1'b0}}, re};
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    full_nxt   = (wr_ptr_nxt[L-1] != rd_ptr_nxt[L-1]) &&
                 (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
  end

`ifdef WB4_FIFO_FLUSH_EN
  logic [P_RATIO-1:0] push_mask;
  logic [P_RATIO-1:0] mem_mask [P_DEPTH];

  assign flush_ok = i_wb4_in_scyc & i_wb4_in_sflush & ~o_wb4_in_sstall;

  // Filled lanes follow the fill order: from lane 0 upward when LSB-first,
  // from the top lane downward otherwise.
  always_comb begin
    push_mask = '0;
    for (int i = 0; i < P_RATIO; i++) begin
      if (complete)
        push_mask[i] = 1'b1;
      else if (P_LSB_FIRST)
        push_mask[i] = (i < fill_cnt);
      else
        push_mask[i] = (i >= P_RATIO - fill_cnt);
    end
  end

  always_ff @(posedge i_wb4_sclk) begin
    if (push) mem_mask[wr_ptr[AW-1:0]] <= push_mask;
  end

  assign head_mask = mem_mask[rd_ptr[AW-1:0]];
`else
  logic unused_flush;
  assign unused_flush = i_wb4_in_sflush;
  assign flush_ok     = 1'b0;
  assign head_mask    = '1;
`endif

  // Storage array is deliberately left without reset.
  always_ff @(posedge i_wb4_sclk) begin
    if (push) mem_data[wr_ptr[AW-1:0]] <= asm_nxt;
  end

  always_ff @(posedge i_wb4_sclk or negedge i_wb4_srst_n) begin
    if (!i_wb4_srst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      o_level          <= '0;
      o_wb4_in_sstall  <= 1'b0;
      o_wb4_out_sstall <= 1'b1;
      o_wb4_in_sack    <= 1'b0;
      o_wb4_out_sack   <= 1'b0;
      o_wb4_out_sdata  <= '0;
      o_wb4_out_smask  <= '0;
      r_unit_cnt       <= '0;
      r_asm            <= '0;
    end else begin
      wr_ptr           <= wr_ptr_nxt;
      rd_ptr           <= rd_ptr_nxt;
      o_level          <= level_nxt;
      o_wb4_in_sstall  <= full_nxt;
      o_wb4_out_sstall <= empty_nxt;
      o_wb4_in_sack    <= we;
      o_wb4_out_sack   <= re;
      // Clearing the assembly register on push keeps unfilled lanes of a
      // later partial word at zero.
      if (push) begin
        r_asm      <= '0;
        r_unit_cnt <= '0;
      end else if (we) begin
        r_asm      <= asm_nxt;
        r_unit_cnt <= r_unit_cnt + CW'(1);
      end
      if (re) begin
        o_wb4_out_sdata <= mem_data[rd_ptr[AW-1:0]];
        o_wb4_out_smask <= head_mask;
      end
    end
  end

endmodule
